// File: rtl/axi_wr_slave_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_slave_ram_pkg
//  Purpose  : Shared AXI burst/response encodings and FSM state type for the
//             AXI write-channel slave RAM.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_wr_slave_ram_pkg;

    // AXI4 AWBURST encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // AXI4 BRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    // WRAP is handled like INCR; only FIXED holds the address
    function automatic logic burst_advances(input logic [1:0] burst);
        return (burst != BURST_FIXED);
    endfunction

endpackage : axi_wr_slave_ram_pkg
`default_nettype wire

// File: rtl/axi_ram_bytewr.sv
`default_nettype none
// ============================================================================
//  Module   : axi_ram_bytewr
//  Purpose  : MEM_WORDS x DATA_WIDTH RAM with per-byte write enables, one
//             write port and one registered read port (read returns the
//             pre-write contents when read and write hit the same edge).
//  Revision : 1.0 - initial release
// ============================================================================
module axi_ram_bytewr #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH/8-1:0]       we,
    input  logic [$clog2(MEM_WORDS)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [$clog2(MEM_WORDS)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Storage is intentionally left without reset
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Registered read; output register cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule : axi_ram_bytewr
`default_nettype wire

// File: rtl/axi_wr_slave_ram.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_slave_ram
//  Purpose  : AXI4 write-channel slave backed by an on-chip word RAM. Accepts
//             one AW burst, consumes awlen+1 W beats (counted, no wlast),
//             writes them with byte strobes, then returns a B response.
//             Read channel tied off; debug port exposes RAM contents.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_wr_slave_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    // AW channel
    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic [1:0]                    s_axi_awburst,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    // W channel
    input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    // B channel
    output logic                          s_axi_bvalid,
    output logic [1:0]                    s_axi_bresp,
    input  logic                          s_axi_bready,
    // Read channel (tied off)
    output logic                          s_axi_arready,
    output logic                          s_axi_rvalid,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    // Debug read port
    input  logic [$clog2(MEM_WORDS)-1:0]  dbg_raddr,
    output logic [DATA_WIDTH-1:0]         dbg_rdata,
    output logic                          burst_done
);

    import axi_wr_slave_ram_pkg::*;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    // One spare bit so a burst running past the top of the address map
    // never aliases back into range
    localparam int WA_W   = ADDR_WIDTH - OFFS_W + 1;

    wr_state_t          state;
    logic [WA_W-1:0]    word_addr;
    logic [8:0]         beats_left;
    logic [1:0]         burst;
    logic               err;

    logic               w_hs;
    logic               in_range;
    logic [STRB_W-1:0]  ram_we;
    logic               unused_inputs;

    // AR/R outputs held inactive
    assign s_axi_arready = 1'b0;
    assign s_axi_rvalid  = 1'b0;
    assign s_axi_rdata   = '0;

    // Stride is fixed at the bus width, so awsize and the byte offset bits
    // of awaddr carry no information here
    assign unused_inputs = ^{s_axi_awsize, s_axi_awaddr[OFFS_W-1:0]};

    assign w_hs       = s_axi_wvalid & s_axi_wready;
    assign in_range   = (word_addr < WA_W'(MEM_WORDS));
    assign ram_we     = {STRB_W{w_hs & in_range & ~rst}} & s_axi_wstrb;
    assign burst_done = s_axi_bvalid & s_axi_bready;

    axi_ram_bytewr #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (word_addr[IDX_W-1:0]),
        .wdata (s_axi_wdata),
        .raddr (dbg_raddr),
        .rdata (dbg_rdata)
    );

    // Transaction FSM with registered handshake outputs, beat counter,
    // address generator and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            word_addr     <= '0;
            beats_left    <= '0;
            burst         <= BURST_FIXED;
            err           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        word_addr     <= {1'b0, s_axi_awaddr[ADDR_WIDTH-1:OFFS_W]};
                        beats_left    <= {1'b0, s_axi_awlen} + 9'd1;
                        burst         <= s_axi_awburst;
                        err           <= (s_axi_awburst == BURST_RSVD);
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (burst_advances(burst)) begin
                            word_addr <= word_addr + WA_W'(1);
                        end
                        beats_left <= beats_left - 9'd1;
                        if (!in_range) begin
                            err <= 1'b1;
                        end
                        if (beats_left == 9'd1) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (err || !in_range) ? RESP_SLVERR : RESP_OKAY;
                            state        <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        s_axi_awready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : axi_wr_slave_ram
`default_nettype wire
